// File: rtl/mario_sound_out.sv
// mario_sound_out: boxcar decimator, optional DC blocker and click-free volume ramp for the mixed sound.
module mario_sound_out #(
  parameter int LOG2_DIV = 8,
  parameter int DC_SHIFT = 8
) (
  input  logic               I_CLK_12M,
  input  logic               I_RST,
  input  logic signed [15:0] I_SND_DAT,
  input  logic               I_DC_EN,
  input  logic [3:0]         I_VOL,
  input  logic               I_MUTE,
  output logic signed [15:0] O_SAMPLE,
  output logic               O_VALID,
  output logic               O_CLIP
);
  localparam int AW = 16 + LOG2_DIV;
  logic [LOG2_DIV-1:0] cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic signed [15:0] avg_q, avg_d, x1_q, x1_d, y1_q, y1_d, y_q, y_d, smp_q, smp_d, y_dc;
  logic s0_v_q, s0_v_d, s1_v_q, clip_q, clip_d, valid_q, oclip_q, oclip_d, last, sat_hi, sat_lo;
  logic [4:0] gain_q, gain_d, target;
  logic signed [18:0] a19, x19, y19, l19, t;
  logic signed [20:0] prod;
  always_comb begin
    last   = &cnt_q;
    sum    = acc_q + {{LOG2_DIV{I_SND_DAT[15]}}, I_SND_DAT};
    cnt_d  = cnt_q + LOG2_DIV'(1);
    acc_d  = last ? '0 : sum;
    avg_d  = last ? 16'(sum >>> LOG2_DIV) : avg_q;
    s0_v_d = last;
    a19    = avg_q;
    x19    = x1_q;
    y19    = y1_q;
    l19    = y1_q >>> DC_SHIFT;
    t      = a19 - x19 + y19 - l19;
    sat_hi = t > 19'sd32767;
    sat_lo = t < -19'sd32768;
    y_dc   = sat_hi ? 16'sh7fff : sat_lo ? 16'sh8000 : t[15:0];
    y_d    = s0_v_q ? (I_DC_EN ? y_dc : avg_q) : y_q;
    clip_d = s0_v_q ? (I_DC_EN & (sat_hi | sat_lo)) : clip_q;
    x1_d   = s0_v_q ? avg_q : x1_q;
    y1_d   = s0_v_q ? (I_DC_EN ? y_dc : 16'sd0) : y1_q;
    prod   = y_q * $signed({1'b0, gain_q});
    smp_d  = s1_v_q ? 16'(prod >>> 4) : smp_q;
    oclip_d = s1_v_q & clip_q;
    // gain steps toward target only after the current value has been used
    target = I_MUTE ? 5'd0 : {1'b0, I_VOL} + 5'd1;
    gain_d = !s1_v_q ? gain_q :
             (gain_q < target) ? gain_q + 5'd1 :
             (gain_q > target) ? gain_q - 5'd1 : gain_q;
  end
  always_ff @(posedge I_CLK_12M or posedge I_RST) begin
    if (I_RST) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      avg_q   <= '0;
      s0_v_q  <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      y_q     <= '0;
      clip_q  <= 1'b0;
      s1_v_q  <= 1'b0;
      gain_q  <= '0;
      smp_q   <= '0;
      valid_q <= 1'b0;
      oclip_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      avg_q   <= avg_d;
      s0_v_q  <= s0_v_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      y_q     <= y_d;
      clip_q  <= clip_d;
      s1_v_q  <= s0_v_q;
      gain_q  <= gain_d;
      smp_q   <= smp_d;
      valid_q <= s1_v_q;
      oclip_q <= oclip_d;
    end
  end
  assign O_SAMPLE = smp_q;
  assign O_VALID  = valid_q;
  assign O_CLIP   = oclip_q;
endmodule

// File: tb/tb_mario_sound_out.sv
// tb_mario_sound_out: random and directed stimulus against a per-window arithmetic reference model.
module tb_mario_sound_out;
  logic clk = 1'b0;
  logic rst, mute, dc_en, valid, clip;
  logic signed [15:0] dat, smp;
  logic [3:0] vol;
  int tests, fails, k, first_k, prev_k;
  int m_x1, m_y1, m_gain, m_hold, m_avg, m_y, exp_s;
  bit m_c, p1, p2, exp_v, exp_c;
  longint m_sum;
  int hist[$];
  bit hist_c[$];

  mario_sound_out dut (
    .I_CLK_12M(clk), .I_RST(rst), .I_SND_DAT(dat), .I_DC_EN(dc_en),
    .I_VOL(vol), .I_MUTE(mute), .O_SAMPLE(smp), .O_VALID(valid), .O_CLIP(clip)
  );

  always #5 clk = ~clk;

  function automatic int floordiv(input longint a, input int b);
    longint q = a / b;
    if ((a % b) != 0 && a < 0) q--;
    return int'(q);
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, expv, k);
    end
  endtask

  // model follows the sampling points: DC_EN one clock after window end, VOL/MUTE two clocks after
  task automatic step(input int d);
    int t, tg;
    dat = 16'(d);
    @(posedge clk);
    k++;
    exp_v = 0;
    if (p2) begin
      exp_v = 1;
      exp_s = floordiv(longint'(m_y) * m_gain, 16);
      exp_c = m_c;
      tg = mute ? 0 : int'(vol) + 1;
      if (m_gain < tg) m_gain++;
      else if (m_gain > tg) m_gain--;
      p2 = 0;
    end
    if (p1) begin
      if (dc_en) begin
        t = m_avg - m_x1 + m_y1 - floordiv(m_y1, 256);
        m_y = t > 32767 ? 32767 : (t < -32768 ? -32768 : t);
        m_c = (t != m_y);
        m_y1 = m_y;
      end else begin
        m_y = m_avg;
        m_c = 0;
        m_y1 = 0;
      end
      m_x1 = m_avg;
      p1 = 0;
      p2 = 1;
    end
    m_sum += d;
    if (k % 256 == 0) begin
      m_avg = floordiv(m_sum, 256);
      m_sum = 0;
      p1 = 1;
    end
    #1;
    if (exp_v) begin
      chk("valid", int'(valid), 1);
      chk("sample", int'(smp), exp_s);
      chk("clip", int'(clip), int'(exp_c));
      if (first_k < 0) first_k = k;
      if (prev_k >= 0) chk("period", k - prev_k, 256);
      prev_k = k;
      m_hold = exp_s;
      hist.push_back(int'(smp));
      hist_c.push_back(clip);
    end else begin
      chk("valid_idle", int'(valid), 0);
      chk("clip_idle", int'(clip), 0);
      chk("hold", int'(smp), m_hold);
    end
  endtask

  task automatic run(input int n, input int v);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_sample", int'(smp), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_clip", int'(clip), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0; m_sum = 0; m_x1 = 0; m_y1 = 0; m_gain = 0; m_hold = 0;
    p1 = 0; p2 = 0; first_k = -1; prev_k = -1;
    hist.delete();
    hist_c.delete();
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b0; dat = '0; dc_en = 1'b0; vol = 4'd15; mute = 1'b0;
    #2;
    do_reset();
    // constant input, gain ramp from zero
    run(18 * 256, 1000);
    chk("first_strobe_k", first_k, 258);
    chk("ramp_0", hist[0], 0);
    chk("ramp_1", hist[1], 62);
    chk("ramp_2", hist[2], 125);
    chk("ramp_16", hist[16], 1000);
    // floor averaging of a single -1
    run(255, 0);
    run(1, -1);
    run(2, 0);
    chk("avg_floor_neg1", hist[hist.size() - 1], -1);
    // DC step response
    dc_en = 1'b1;
    do_reset();
    run(17 * 256, 0);
    hist.delete();
    hist_c.delete();
    run(3 * 256 + 2, 10000);
    chk("dc_step_0", hist[1], 10000);
    chk("dc_step_1", hist[2], 9961);
    chk("dc_step_2", hist[3], 9923);
    chk("dc_step_clip", int'(hist_c[2]), 0);
    // saturation
    do_reset();
    run(17 * 256, 0);
    hist.delete();
    hist_c.delete();
    run(256, -32768);
    run(256, 32767);
    run(258, 0);
    chk("sat_neg", hist[1], -32768);
    chk("sat_neg_clip", int'(hist_c[1]), 0);
    chk("sat_pos", hist[2], 32767);
    chk("sat_pos_clip", int'(hist_c[2]), 1);
    chk("sat_after", hist[3], -127);
    // mute ramp
    dc_en = 1'b0;
    do_reset();
    run(17 * 256, 8000);
    mute = 1'b1;
    hist.delete();
    hist_c.delete();
    run(17 * 256 + 2, 8000);
    chk("mute_0", hist[0], 8000);
    chk("mute_1", hist[1], 7500);
    chk("mute_16", hist[16], 0);
    for (int i = 1; i < 17; i++)
      chk("mute_step_le500", int'(hist[i - 1] - hist[i] <= 500 && hist[i] <= hist[i - 1]), 1);
    // async reset at cnt = 100
    mute = 1'b0;
    run(4 * 256 - 2 + 100, 5000);
    chk("pre_reset_nonzero", int'(smp != 0), 1);
    do_reset();
    run(2 * 256 + 2, 3000);
    chk("post_reset_first_k", first_k, 258);
    // randomized windows and controls
    do_reset();
    for (int w = 0; w < 24; w++) begin
      dc_en = 1'($urandom_range(0, 1));
      vol = 4'($urandom_range(0, 15));
      mute = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 256; i++)
        step((w % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                          : int'($urandom_range(0, 4000)) - 2000 + (w * 300));
    end
    run(2, 0);
    chk("random_strobes", hist.size(), 24);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
